// File: rtl/fwd_pkg.sv
// Shared types and constants for the operand-forwarding control unit.
// The STALL_COUNT_EN build option is handled in the interface and the top module.
package fwd_pkg;

    localparam int AW = 5;

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_EX = 2'b01;
    localparam logic [1:0] SEL_DM = 2'b10;
    localparam logic [1:0] SEL_WB = 2'b11;

    typedef struct packed {
        logic          vld;
        logic          we;
        logic          ld;
        logic [AW-1:0] rw;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '0;

endpackage

// File: rtl/forward_ctrl_unit_if.sv
// Decode-slot info and operand-select results exchanged with the forwarding unit.
// STALL_COUNT_EN adds the stall_count observation bus.
interface forward_ctrl_unit_if;
    import fwd_pkg::*;

    logic          id_valid;
    logic [AW-1:0] RA;
    logic [AW-1:0] RB;
    logic [AW-1:0] RW_id;
    logic          we_id;
    logic          load_id;
    logic          imm_sel_id;
    logic          flush;
    logic [1:0]    mux_sel_A;
    logic [1:0]    mux_sel_B;
    logic          imm_sel;
    logic          stall;
`ifdef STALL_COUNT_EN
    logic [15:0]   stall_count;

    modport master (
        output id_valid, RA, RB, RW_id, we_id, load_id, imm_sel_id, flush,
        input  mux_sel_A, mux_sel_B, imm_sel, stall, stall_count
    );
    modport slave (
        input  id_valid, RA, RB, RW_id, we_id, load_id, imm_sel_id, flush,
        output mux_sel_A, mux_sel_B, imm_sel, stall, stall_count
    );
`else
    modport master (
        output id_valid, RA, RB, RW_id, we_id, load_id, imm_sel_id, flush,
        input  mux_sel_A, mux_sel_B, imm_sel, stall
    );
    modport slave (
        input  id_valid, RA, RB, RW_id, we_id, load_id, imm_sel_id, flush,
        output mux_sel_A, mux_sel_B, imm_sel, stall
    );
`endif

endinterface

// File: rtl/fwd_match.sv
// Compares one source register against the destination held by one pipeline stage.
module fwd_match
    import fwd_pkg::*;
#(
    parameter bit R0_ZERO = 1'b1
) (
    input  logic [AW-1:0] r,
    input  stage_t        st,
    output logic          hit
);

    logic r_is_zero;
    logic unused_ld;

    assign r_is_zero = (r == '0);
    assign hit       = st.vld & st.we & (st.rw == r) & ~(R0_ZERO & r_is_zero);

    // The load flag only matters for the EX instance, which the top reads directly.
    assign unused_ld = st.ld;

endmodule

// File: rtl/forward_ctrl_unit.sv
// Forwarding-mux select and load-use stall generation for the decode stage.
// Define STALL_COUNT_EN to add a saturating 16-bit stall_count on the interface.
module forward_ctrl_unit
    import fwd_pkg::*;
#(
    parameter bit R0_ZERO = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    forward_ctrl_unit_if.slave bus
);

    stage_t ex_q, dm_q, wb_q;
    stage_t id_info;
    logic   hit_a_ex, hit_a_dm, hit_a_wb;
    logic   hit_b_ex, hit_b_dm, hit_b_wb;
    logic   stall_int;
    logic [1:0] sel_a, sel_b;
    logic   imm_out, stall_out;

    fwd_match #(.R0_ZERO(R0_ZERO)) u_a_ex (.r(bus.RA), .st(ex_q), .hit(hit_a_ex));
    fwd_match #(.R0_ZERO(R0_ZERO)) u_a_dm (.r(bus.RA), .st(dm_q), .hit(hit_a_dm));
    fwd_match #(.R0_ZERO(R0_ZERO)) u_a_wb (.r(bus.RA), .st(wb_q), .hit(hit_a_wb));
    fwd_match #(.R0_ZERO(R0_ZERO)) u_b_ex (.r(bus.RB), .st(ex_q), .hit(hit_b_ex));
    fwd_match #(.R0_ZERO(R0_ZERO)) u_b_dm (.r(bus.RB), .st(dm_q), .hit(hit_b_dm));
    fwd_match #(.R0_ZERO(R0_ZERO)) u_b_wb (.r(bus.RB), .st(wb_q), .hit(hit_b_wb));

    function automatic logic [1:0] pick_src(input logic ex, input logic dm, input logic wb);
        if (ex)      return SEL_EX;
        else if (dm) return SEL_DM;
        else if (wb) return SEL_WB;
        else         return SEL_RF;
    endfunction

    assign stall_int = bus.id_valid & ~bus.flush & ex_q.ld &
                       (hit_a_ex | (~bus.imm_sel_id & hit_b_ex));

    // A stalled or flushed decode slot enters EX as a bubble.
    always_comb begin
        id_info     = STAGE_EMPTY;
        id_info.vld = bus.id_valid & ~stall_int & ~bus.flush;
        id_info.we  = bus.we_id;
        id_info.ld  = bus.load_id & id_info.vld;
        id_info.rw  = bus.RW_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= STAGE_EMPTY;
            dm_q <= STAGE_EMPTY;
            wb_q <= STAGE_EMPTY;
        end else begin
            ex_q <= id_info;
            dm_q <= ex_q;
            wb_q <= dm_q;
        end
    end

    // Outputs are forced low for the whole time reset is asserted, not just after the edge.
    always_comb begin
        sel_a     = SEL_RF;
        sel_b     = SEL_RF;
        imm_out   = 1'b0;
        stall_out = 1'b0;
        if (rst_n && bus.id_valid) begin
            sel_a     = pick_src(hit_a_ex, hit_a_dm, hit_a_wb);
            sel_b     = bus.imm_sel_id ? SEL_RF : pick_src(hit_b_ex, hit_b_dm, hit_b_wb);
            imm_out   = bus.imm_sel_id;
            stall_out = stall_int;
        end
    end

    assign bus.mux_sel_A = sel_a;
    assign bus.mux_sel_B = sel_b;
    assign bus.imm_sel   = imm_out;
    assign bus.stall     = stall_out;

`ifdef STALL_COUNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_int && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_forward_ctrl_unit.sv
// Scoreboard bench for forward_ctrl_unit: directed hazard scenarios plus random traffic.
// Build with STALL_COUNT_EN defined to also check stall_count.
module tb_forward_ctrl_unit;
    import fwd_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    forward_ctrl_unit_if bus();

    forward_ctrl_unit #(.R0_ZERO(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit vld;
        bit we;
        bit ld;
        int rw;
    } instr_t;

    typedef struct {
        bit [1:0] sa;
        bit [1:0] sb;
        bit       imm;
        bit       stall;
        int       cnt;
    } exp_t;

    // pipe[0] = instruction now in EX, pipe[1] = DM, pipe[2] = WB
    instr_t pipe[3];
    exp_t   sb_q[$];
    int     total = 0;
    int     bad = 0;
    int     model_cnt = 0;

    function automatic void clear_model();
        for (int i = 0; i < 3; i++) pipe[i] = '{vld: 0, we: 0, ld: 0, rw: 0};
        model_cnt = 0;
    endfunction

    // Distance (1..3) to the youngest in-flight writer of r, 0 when the regfile is current.
    function automatic int producer(int r);
        if (r == 0) return 0;
        for (int i = 0; i < 3; i++)
            if (pipe[i].vld && pipe[i].we && pipe[i].rw == r) return i + 1;
        return 0;
    endfunction

    task automatic step(bit v, int ra, int rb, int rw, bit we, bit ld, bit imm, bit fl);
        exp_t   e;
        int     pa, pb;
        bit     st;
        @(posedge clk);
        #1;
        bus.id_valid   = v;
        bus.RA         = AW'(ra);
        bus.RB         = AW'(rb);
        bus.RW_id      = AW'(rw);
        bus.we_id      = we;
        bus.load_id    = ld;
        bus.imm_sel_id = imm;
        bus.flush      = fl;
        e = '{sa: 0, sb: 0, imm: 0, stall: 0, cnt: 0};
        if (rst_n) begin
            pa = producer(ra);
            pb = producer(rb);
            st = v && !fl && pipe[0].ld && (pa == 1 || (!imm && pb == 1));
            e.cnt = model_cnt;
            if (v) begin
                e.sa    = 2'(pa);
                e.sb    = imm ? 2'd0 : 2'(pb);
                e.imm   = imm;
                e.stall = st;
            end
            sb_q.push_back(e);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{vld: v && !st && !fl, we: we, ld: ld, rw: rw};
            if (st && model_cnt < 65535) model_cnt++;
        end else begin
            clear_model();
            sb_q.push_back(e);
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                total++;
                if ({bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall} !==
                    {e.sa, e.sb, e.imm, e.stall}) begin
                    bad++;
                    $display("FAIL scoreboard t=%0t got selA=%0d selB=%0d imm=%0d stall=%0d want selA=%0d selB=%0d imm=%0d stall=%0d",
                             $time, bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall,
                             e.sa, e.sb, e.imm, e.stall);
                end
`ifdef STALL_COUNT_EN
                total++;
                if (bus.stall_count !== 16'(e.cnt)) begin
                    bad++;
                    $display("FAIL stall_count t=%0t got %0d want %0d", $time, bus.stall_count, e.cnt);
                end
`endif
            end
        end
    end

    task automatic release_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : stim
        bus.id_valid = 0; bus.RA = '0; bus.RB = '0; bus.RW_id = '0;
        bus.we_id = 0; bus.load_id = 0; bus.imm_sel_id = 0; bus.flush = 0;
        clear_model();
        rst_n = 1'b0;
        step(1, 3, 4, 5, 1, 1, 1, 0);   // inputs active during reset still give zeros
        idle();
        release_reset();

        // ALU chain
        step(1, 1, 2, 7, 1, 0, 0, 0);
        step(1, 7, 3, 8, 1, 0, 0, 0);
        step(1, 7, 3, 9, 0, 0, 0, 0);
        // youngest producer wins, then WB-only producer
        step(1, 1, 1, 5, 1, 0, 0, 0);
        step(1, 1, 1, 5, 1, 0, 0, 0);
        step(1, 1, 1, 5, 1, 0, 0, 0);
        step(1, 5, 5, 9, 1, 0, 0, 0);
        step(1, 2, 2, 5, 1, 0, 0, 0);
        step(1, 2, 2, 9, 1, 0, 0, 0);
        step(1, 2, 2, 9, 1, 0, 0, 0);
        step(1, 5, 5, 10, 0, 0, 0, 0);
        // load-use on RB, held for one cycle
        step(1, 1, 2, 6, 1, 1, 0, 0);
        step(1, 3, 6, 12, 1, 0, 0, 0);
        step(1, 3, 6, 12, 1, 0, 0, 0);
        // load followed by immediate-B user: no stall
        step(1, 1, 2, 6, 1, 1, 0, 0);
        step(1, 3, 6, 12, 1, 0, 1, 0);
        // r0 never forwards or stalls
        step(1, 1, 2, 0, 1, 1, 0, 0);
        step(1, 0, 0, 4, 1, 0, 0, 0);
        // flush beats stall; flushed writer never forwards
        step(1, 1, 2, 6, 1, 1, 0, 0);
        step(1, 6, 2, 11, 1, 0, 0, 1);
        step(1, 11, 11, 3, 0, 0, 0, 0);
        // id_valid low hides everything
        step(1, 1, 2, 13, 1, 1, 0, 0);
        step(0, 13, 13, 0, 0, 0, 1, 0);

        // reset in the middle of a stall
        step(1, 1, 2, 6, 1, 1, 0, 0);
        step(1, 6, 6, 12, 1, 0, 0, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall} !== 6'd0) begin
            bad++;
            $display("FAIL async_reset got selA=%0d selB=%0d imm=%0d stall=%0d want all 0",
                     bus.mux_sel_A, bus.mux_sel_B, bus.imm_sel, bus.stall);
        end
        clear_model();
        idle();
        release_reset();
        step(1, 6, 6, 1, 0, 0, 0, 0);

        // three load-use stalls
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 2, 6, 1, 1, 0, 0);
            step(1, 6, 2, 12, 0, 0, 0, 0);
            step(1, 6, 2, 12, 0, 0, 0, 0);
        end

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) < 85,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10);
        end

        repeat (3) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
